// File: rtl/div_rem_sgn_seq_if.sv
// Handshake bundle for the sequential signed divider: operand channel in, result channel out.
// The slave modport is the divider side; the master modport is the producer/consumer side.
interface div_rem_sgn_seq_if #(
  parameter int BW = 8
);
  localparam int WN = 2 * BW;
  localparam int WD = BW;

  logic          in_valid_i;
  logic          in_ready_o;
  logic [WN-1:0] n_i;
  logic [WD-1:0] d_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [WN-1:0] q_o;
  logic [WD-1:0] r_o;
  logic          dz_o;
  logic          ovf_o;

  modport slave (
    input  in_valid_i, n_i, d_i, out_ready_i,
    output in_ready_o, out_valid_o, q_o, r_o, dz_o, ovf_o
  );

  modport master (
    output in_valid_i, n_i, d_i, out_ready_i,
    input  in_ready_o, out_valid_o, q_o, r_o, dz_o, ovf_o
  );
endinterface

// File: rtl/div_rem_sgn_seq.sv
// Sequential signed divider: N = Q*D + R with truncation toward zero, one quotient bit per
// cycle via restoring division on magnitudes, signs and special cases applied in a fix-up state.
module div_rem_sgn_seq #(
  parameter int BW = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  div_rem_sgn_seq_if.slave     bus
);
  localparam int WN = 2 * BW;
  localparam int WD = BW;
  localparam int CW = $clog2(WN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [WN-1:0] r_n;
  logic [WD-1:0] r_d;
  logic [WD:0]   r_p;
  logic          r_sn;
  logic          r_sd;
  logic          r_dz;
  logic          r_ovf;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [WN-1:0] r_q;
  logic [WD-1:0] r_r;
  logic          r_dz_o;
  logic          r_ovf_o;

  logic [WN-1:0] w_n_abs;
  logic [WD-1:0] w_d_abs;
  logic          w_ovf_in;
  logic [WD:0]   w_shift;
  logic [WD+1:0] w_diff;
  logic          w_ge;
  logic [WD-1:0] w_r_mag;

  // Magnitudes are unsigned, so the most negative operand maps onto 2^(width-1) correctly.
  assign w_n_abs  = bus.n_i[WN-1] ? -bus.n_i : bus.n_i;
  assign w_d_abs  = bus.d_i[WD-1] ? -bus.d_i : bus.d_i;
  assign w_ovf_in = (bus.n_i == {1'b1, {(WN-1){1'b0}}}) && (bus.d_i == {WD{1'b1}});

  // r_n doubles as the dividend shifter and the quotient accumulator.
  assign w_shift = {r_p[WD-1:0], r_n[WN-1]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, r_d};
  assign w_ge    = ~w_diff[WD+1];
  assign w_r_mag = r_p[WD-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_n         <= '0;
      r_d         <= '0;
      r_p         <= '0;
      r_sn        <= 1'b0;
      r_sd        <= 1'b0;
      r_dz        <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_q         <= '0;
      r_r         <= '0;
      r_dz_o      <= 1'b0;
      r_ovf_o     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid_i) begin
            r_n        <= w_n_abs;
            r_d        <= w_d_abs;
            r_p        <= '0;
            r_sn       <= bus.n_i[WN-1];
            r_sd       <= bus.d_i[WD-1];
            r_dz       <= (bus.d_i == '0);
            r_ovf      <= w_ovf_in;
            r_cnt      <= CW'(WN - 1);
            r_in_ready <= 1'b0;
            r_state    <= CALC;
          end
        end
        CALC: begin
          r_p <= w_ge ? w_diff[WD:0] : w_shift;
          r_n <= {r_n[WN-2:0], w_ge};
          if (r_cnt == '0) begin
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        FIX: begin
          if (r_dz) begin
            r_q     <= '1;
            r_r     <= '0;
            r_dz_o  <= 1'b1;
            r_ovf_o <= 1'b0;
          end else if (r_ovf) begin
            r_q     <= {1'b1, {(WN-1){1'b0}}};
            r_r     <= '0;
            r_dz_o  <= 1'b0;
            r_ovf_o <= 1'b1;
          end else begin
            r_q     <= (r_sn ^ r_sd) ? -r_n : r_n;
            r_r     <= r_sn ? -w_r_mag : w_r_mag;
            r_dz_o  <= 1'b0;
            r_ovf_o <= 1'b0;
          end
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (bus.out_ready_i) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready_o  = r_in_ready;
  assign bus.out_valid_o = r_out_valid;
  assign bus.q_o         = r_q;
  assign bus.r_o         = r_r;
  assign bus.dz_o        = r_dz_o;
  assign bus.ovf_o       = r_ovf_o;
endmodule

// File: tb/tb_div_rem_sgn_seq.sv
// Scoreboard bench for div_rem_sgn_seq (BW=8): the driver queues expected results, a monitor
// pops and compares whenever a result handshake is about to occur.
module tb_div_rem_sgn_seq;
  typedef struct packed {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  exp_t sb[$];

  div_rem_sgn_seq_if #(.BW(8)) bus();

  div_rem_sgn_seq #(.BW(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic [15:0] q, input logic [7:0] r, input logic dz, input logic ovf);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz; e.ovf = ovf;
    return e;
  endfunction

  function automatic exp_t model(input logic signed [15:0] n, input logic signed [7:0] d);
    int ni, di, qi, ri;
    ni = n;
    di = d;
    if (di == 0) return mk(16'hFFFF, 8'h00, 1'b1, 1'b0);
    if (ni == -32768 && di == -1) return mk(16'h8000, 8'h00, 1'b0, 1'b1);
    qi = ni / di;
    ri = ni - qi * di;
    return mk(qi[15:0], ri[7:0], 1'b0, 1'b0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: a result is consumed at the next rising edge when valid and ready are both high here.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
        a = mk(bus.q_o, bus.r_o, bus.dz_o, bus.ovf_o);
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_result actual q=%h r=%h dz=%b ovf=%b required none",
                   a.q, a.r, a.dz, a.ovf);
        end else begin
          e = sb.pop_front();
          if (a !== e) begin
            fails++;
            $display("FAIL result actual q=%h r=%h dz=%b ovf=%b required q=%h r=%h dz=%b ovf=%b",
                     a.q, a.r, a.dz, a.ovf, e.q, e.r, e.dz, e.ovf);
          end else begin
            $display("[TB] result q=%0d r=%0d dz=%b ovf=%b", $signed(a.q), $signed(a.r), a.dz, a.ovf);
          end
        end
      end
    end
  end

  task automatic issue(input logic [15:0] n, input logic [7:0] d, input exp_t e, input bit push);
    int guard;
    guard = 0;
    while (!bus.in_ready_o && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.in_ready_o) begin
      tests++;
      fails++;
      $display("FAIL in_ready_timeout actual=0 required=1");
    end
    bus.n_i        = n;
    bus.d_i        = d;
    bus.in_valid_i = 1'b1;
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_valid(input bit chk_lat);
    int lat;
    lat = 0;
    while (!bus.out_valid_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (chk_lat) chk("latency", lat, 17);
    else if (!bus.out_valid_o) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic do_op(input logic [15:0] n, input logic [7:0] d, input logic [15:0] q,
                       input logic [7:0] r, input logic dz, input logic ovf);
    issue(n, d, mk(q, r, dz, ovf), 1'b1);
    wait_valid(1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] qh;
    logic [7:0]  rh;
    logic [15:0] rn;
    logic [7:0]  rd;
    bit          seen;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.n_i         = '0;
    bus.d_i         = '0;
    bus.out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready_o, 1);
    chk("rst_out_valid", bus.out_valid_o, 0);
    chk("rst_q", bus.q_o, 0);
    chk("rst_r", bus.r_o, 0);
    chk("rst_flags", {bus.dz_o, bus.ovf_o}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(16'd100,    8'd7,      16'd14,     8'd2,      1'b0, 1'b0);
    do_op(-16'sd100,  8'd7,      -16'sd14,   -8'sd2,    1'b0, 1'b0);
    do_op(16'd100,    -8'sd7,    -16'sd14,   8'd2,      1'b0, 1'b0);
    do_op(-16'sd100,  -8'sd7,    16'd14,     -8'sd2,    1'b0, 1'b0);
    do_op(16'h8000,   8'hFF,     16'h8000,   8'd0,      1'b0, 1'b1);
    do_op(-16'sd128,  -8'sd128,  16'd1,      8'd0,      1'b0, 1'b0);
    do_op(16'd1234,   8'd0,      16'hFFFF,   8'd0,      1'b1, 1'b0);
    do_op(16'h8000,   8'd1,      16'h8000,   8'd0,      1'b0, 1'b0);
    do_op(16'd32767,  -8'sd128,  -16'sd255,  8'd127,    1'b0, 1'b0);
    do_op(16'h8000,   8'd127,    -16'sd258,  -8'sd2,    1'b0, 1'b0);
    do_op(16'd7,      8'd100,    16'd0,      8'd7,      1'b0, 1'b0);
    do_op(16'hFFFF,   8'd0,      16'hFFFF,   8'd0,      1'b1, 1'b0);
    do_op(16'd0,      -8'sd5,    16'd0,      8'd0,      1'b0, 1'b0);

    // Backpressure: result must hold and extra operands must be ignored.
    bus.out_ready_i = 1'b0;
    issue(-16'sd100, -8'sd7, mk(16'd14, -8'sd2, 1'b0, 1'b0), 1'b1);
    wait_valid(1'b1);
    qh = bus.q_o;
    rh = bus.r_o;
    chk("bp_q_value", qh, 16'd14);
    for (int i = 0; i < 5; i++) begin
      bus.n_i        = 16'd5;
      bus.d_i        = 8'd1;
      bus.in_valid_i = (i % 2 == 0);
      @(posedge clk); #1;
      chk("bp_q_stable", bus.q_o, qh);
      chk("bp_r_stable", bus.r_o, rh);
      chk("bp_in_ready", bus.in_ready_o, 0);
      chk("bp_out_valid", bus.out_valid_o, 1);
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", bus.out_valid_o, 0);
    chk("bp_release_in_ready", bus.in_ready_o, 1);
    repeat (25) @(posedge clk);
    #1;
    chk("bp_no_extra_result", bus.out_valid_o, 0);

    // Reset during CALC aborts the operation with no result.
    issue(16'd1000, 8'd3, mk(16'd333, 8'd1, 1'b0, 1'b0), 1'b0);
    repeat (8) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", bus.in_ready_o, 1);
    chk("midrst_out_valid", bus.out_valid_o, 0);
    chk("midrst_q", bus.q_o, 0);
    chk("midrst_r", bus.r_o, 0);
    chk("midrst_flags", {bus.dz_o, bus.ovf_o}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.out_valid_o) seen = 1'b1;
    end
    chk("midrst_no_result", seen, 0);
    do_op(16'd50, -8'sd3, -16'sd16, 8'd2, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      rn = 16'($urandom);
      rd = 8'($urandom);
      if (i % 50 == 0) rd = 8'd0;
      issue(rn, rd, model(rn, rd), 1'b1);
      wait_valid(1'b0);
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
